topk_stream_sorter: RTL and testbench



---
 rtl/topk_stream_sorter.sv | 125 ++++++++++++
 tb/tb_topk_stream_sorter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/topk_stream_sorter.sv
// Streaming top-K selector: keeps a sorted K-slot insertion register of the best
// elements (and their arrival indices) of each last-delimited frame.
module topk_stream_sorter #(
    parameter int DATAWIDTH = 8,
    parameter int K         = 4,
    parameter int IDXWIDTH  = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [DATAWIDTH-1:0]               in_data_i,
    input  logic                               in_last_i,
    input  logic                               sign_ctrl_i,
    input  logic                               min_mode_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [K-1:0][DATAWIDTH-1:0]        y_o,
    output logic [K-1:0][IDXWIDTH-1:0]         idx_o,
    output logic [$clog2(K+1)-1:0]             count_o,
    output logic                               ovf_o
);

    localparam int CNTW = $clog2(K + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state_q, state_d;

    logic                         accept, first_acc;
    logic                         sign_q, min_q, sign_eff, min_eff;
    logic [IDXWIDTH-1:0]          idx_cnt_q, new_idx;
    logic [K-1:0][DATAWIDTH-1:0]  base_val, nxt_val;
    logic [K-1:0][IDXWIDTH-1:0]   base_idx, nxt_idx;
    logic [CNTW-1:0]              base_cnt, nxt_cnt, ins_pos;

    // Existing slot value a ranks at or ahead of new value b; equality keeps the
    // earlier arrival in front.
    function automatic logic better_eq(input logic [DATAWIDTH-1:0] a,
                                       input logic [DATAWIDTH-1:0] b,
                                       input logic sgn,
                                       input logic mn);
        logic gt;
        gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
        return (a == b) || (mn ? !gt : gt);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = in_last_i ? DONE : ACCUM;
            ACCUM:   if (accept && in_last_i) state_d = DONE;
            DONE:    if (out_valid_o && out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q != DONE);
        out_valid_o = (state_q == DONE);
    end

    assign accept    = in_valid_i & in_ready_o;
    assign first_acc = accept & (state_q == IDLE);
    assign sign_eff  = (state_q == IDLE) ? sign_ctrl_i : sign_q;
    assign min_eff   = (state_q == IDLE) ? min_mode_i  : min_q;
    assign new_idx   = first_acc ? '0 : idx_cnt_q;

    // A frame's first element sees an empty register, so the slots are cleared
    // and the element inserted in the same cycle.
    always_comb begin
        base_val = first_acc ? '0 : y_o;
        base_idx = first_acc ? '0 : idx_o;
        base_cnt = first_acc ? '0 : count_o;
        ins_pos  = '0;
        for (int i = 0; i < K; i++) begin
            if (CNTW'(i) < base_cnt && better_eq(base_val[i], in_data_i, sign_eff, min_eff))
                ins_pos = ins_pos + CNTW'(1);
        end
        nxt_val[0] = (ins_pos == '0) ? in_data_i : base_val[0];
        nxt_idx[0] = (ins_pos == '0) ? new_idx   : base_idx[0];
        for (int i = 1; i < K; i++) begin
            if (CNTW'(i) > ins_pos) begin
                nxt_val[i] = base_val[i-1];
                nxt_idx[i] = base_idx[i-1];
            end else if (CNTW'(i) == ins_pos) begin
                nxt_val[i] = in_data_i;
                nxt_idx[i] = new_idx;
            end else begin
                nxt_val[i] = base_val[i];
                nxt_idx[i] = base_idx[i];
            end
        end
        nxt_cnt = (base_cnt == CNTW'(K)) ? base_cnt : base_cnt + CNTW'(1);
    end

    // The counter returning to zero on a non-first element means it has wrapped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y_o       <= '0;
            idx_o     <= '0;
            count_o   <= '0;
            ovf_o     <= 1'b0;
            idx_cnt_q <= '0;
            sign_q    <= 1'b0;
            min_q     <= 1'b0;
        end else if (accept) begin
            y_o       <= nxt_val;
            idx_o     <= nxt_idx;
            count_o   <= nxt_cnt;
            idx_cnt_q <= new_idx + IDXWIDTH'(1);
            ovf_o     <= first_acc ? 1'b0 : (ovf_o | (idx_cnt_q == '0));
            if (first_acc) begin
                sign_q <= sign_ctrl_i;
                min_q  <= min_mode_i;
            end
        end
    end

endmodule

// File: tb/tb_topk_stream_sorter.sv
// Scoreboard bench for topk_stream_sorter: a stable selection model predicts each
// frame's result, compared when the DUT completes the output handshake.
module tb_topk_stream_sorter;

    localparam int DW = 8;
    localparam int K  = 4;
    localparam int IW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_last, sign_ctrl, min_mode, out_ready;
    logic [DW-1:0] in_data;

    logic                 in_ready, out_valid, ovf;
    logic [K-1:0][DW-1:0] y;
    logic [K-1:0][IW-1:0] idx;
    logic [2:0]           count;

    logic                 in_ready2, out_valid2, ovf2;
    logic [K-1:0][DW-1:0] y2;
    logic [K-1:0][1:0]    idx2;
    logic [2:0]           count2;

    topk_stream_sorter #(.DATAWIDTH(DW), .K(K), .IDXWIDTH(IW)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_last_i(in_last), .sign_ctrl_i(sign_ctrl),
        .min_mode_i(min_mode), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .y_o(y), .idx_o(idx), .count_o(count), .ovf_o(ovf)
    );

    topk_stream_sorter #(.DATAWIDTH(DW), .K(K), .IDXWIDTH(2)) u_dut_iw2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .in_data_i(in_data), .in_last_i(in_last), .sign_ctrl_i(sign_ctrl),
        .min_mode_i(min_mode), .out_valid_o(out_valid2), .out_ready_i(out_ready),
        .y_o(y2), .idx_o(idx2), .count_o(count2), .ovf_o(ovf2)
    );

    typedef struct packed {
        logic [K-1:0][DW-1:0] y;
        logic [K-1:0][IW-1:0] idx;
        logic [2:0]           cnt;
        logic                 ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int key(input int v, input bit sgn);
        logic [7:0] b;
        b = v[7:0];
        return sgn ? int'($signed(b)) : int'(b);
    endfunction

    // Repeated selection of the best remaining element, earliest arrival on ties.
    function automatic exp_t model(input int vals[$], input bit sgn, input bit mn);
        exp_t e;
        bit   used[];
        int   n;
        int   v;
        n = vals.size();
        e = '0;
        used = new[n];
        for (int k = 0; k < K && k < n; k++) begin
            int best;
            best = -1;
            for (int j = 0; j < n; j++) begin
                if (!used[j]) begin
                    if (best < 0) best = j;
                    else if (mn ? (key(vals[j], sgn) < key(vals[best], sgn))
                                : (key(vals[j], sgn) > key(vals[best], sgn))) best = j;
                end
            end
            used[best] = 1'b1;
            v = vals[best];
            e.y[k]   = v[7:0];
            e.idx[k] = best[7:0];
        end
        e.cnt = (n > K) ? 3'(K) : 3'(n);
        e.ovf = (n > 256);
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("sb_y", y, e.y);
                chk("sb_idx", idx, e.idx);
                chk("sb_count", count, e.cnt);
                chk("sb_ovf", ovf, e.ovf);
            end
        end
    end

    // Entered at a negedge or just after a posedge; returns just after the last
    // accepting edge, or at the following negedge when the frame is closed.
    task automatic run_frame(input int vals[$], input bit sgn, input bit mn,
                             input bit toggle, input bit do_last);
        int   g;
        int   v;
        logic rdy;
        if (do_last) exp_q.push_back(model(vals, sgn, mn));
        for (int i = 0; i < vals.size(); i++) begin
            v         = vals[i];
            in_valid  = 1'b1;
            in_data   = v[7:0];
            in_last   = do_last && (i == vals.size() - 1);
            sign_ctrl = (toggle && i > 0) ? ~sgn : sgn;
            min_mode  = (toggle && i > 0) ? ~mn  : mn;
            g = 0;
            do begin
                rdy = in_ready;
                @(posedge clk);
                #1;
                g++;
            end while (!rdy && g < 20);
            if (!rdy) chk("accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (do_last) begin
            @(negedge clk);
            chk("latency_out_valid", out_valid, 1'b1);
        end
    endtask

    task automatic wait_sb();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("sb_drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals1[$];
        int vals2[$];
        int vals3[$];
        int rq[$];
        int len;
        logic [K-1:0][DW-1:0] snap_y;

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        sign_ctrl = 1'b0; min_mode = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_y", y, '0);
        chk("rst_ovf", ovf, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);

        // Unsigned max
        vals1 = '{0, 18, 23, 35, 40, 60, 90, 95, 20, 14, 12, 10, 9, 8, 5, 3};
        run_frame(vals1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("c1_y", y, {8'd40, 8'd60, 8'd90, 8'd95});
        chk("c1_idx", idx, {8'd4, 8'd5, 8'd6, 8'd7});
        wait_sb();

        // Signed max, then the same stream compared unsigned
        vals2 = '{-100, -95, -90, -60, -40, -20, -18, -14, -8, -5, -1, 0, 5, 10, 25, 35};
        run_frame(vals2, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("c2s_y", y, {8'd5, 8'd10, 8'd25, 8'd35});
        chk("c2s_idx", idx, {8'd12, 8'd13, 8'd14, 8'd15});
        wait_sb();
        run_frame(vals2, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("c2u_y", y, {8'hF2, 8'hF8, 8'hFB, 8'hFF});
        chk("c2u_idx", idx, {8'd7, 8'd8, 8'd9, 8'd10});
        wait_sb();

        // Unsigned min, plain and with mode inputs toggled mid-frame
        vals3 = '{5, 7, 9, 1, 0, 2, 3, 6, 8, 15, 14, 12, 13, 10, 11, 4};
        run_frame(vals3, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_sb();
        run_frame(vals3, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("c3t_y", y, {8'd3, 8'd2, 8'd1, 8'd0});
        chk("c3t_idx", idx, {8'd6, 8'd5, 8'd3, 8'd4});
        wait_sb();

        // Ties in a short frame, then a single-element frame
        run_frame('{7, 7, 3}, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("c4_y", y, {8'd0, 8'd3, 8'd7, 8'd7});
        chk("c4_idx", idx, {8'd0, 8'd2, 8'd1, 8'd0});
        chk("c4_count", count, 3'd3);
        chk("c4_iw2_ovf", ovf2, 1'b0);
        wait_sb();
        run_frame('{42}, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("c4b_count", count, 3'd1);
        wait_sb();

        // Output backpressure with a pending input element
        out_ready = 1'b0;
        run_frame('{9, 4, 11}, 1'b0, 1'b0, 1'b0, 1'b1);
        snap_y   = y;
        in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_y_hold", y, snap_y);
            chk("bp_count_hold", count, 3'd3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", in_ready, 1'b1);
        chk("bp_out_valid_after", out_valid, 1'b0);
        @(negedge clk);
        run_frame('{5, 6}, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_sb();

        // Reset asserted mid-frame discards the partial frame
        run_frame('{1, 2, 3}, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_count", count, 3'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        run_frame(vals1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_y", y, {8'd40, 8'd60, 8'd90, 8'd95});
        wait_sb();

        // Index wrap on the 2-bit-index instance
        run_frame('{1, 2, 3, 4, 50}, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("iw2_ovf", ovf2, 1'b1);
        chk("iw2_last_idx", idx2[0], 2'd0);
        chk("iw2_best_y", y2[0], 8'd50);
        wait_sb();

        // Random frames, some with a narrow value range to force ties
        for (int f = 0; f < 8; f++) begin
            rq.delete();
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++)
                rq.push_back((f % 2) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255)));
            run_frame(rq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            wait_sb();
        end

        // Frame longer than the index range sets ovf
        rq.delete();
        for (int i = 0; i < 260; i++) rq.push_back(int'($urandom_range(0, 255)));
        run_frame(rq, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_sb();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
